// File: rtl/crc_serial_engine.sv
// rtl/crc_serial_engine.sv - bit-serial CRC accumulator with parallel result and MSB-first serial CRC output
module crc_serial_engine #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] POLY     = 8'h07,
    parameter logic [WIDTH-1:0] INIT     = 8'h00,
    parameter int               MAX_BITS = 256,
    localparam int              CW       = $clog2(MAX_BITS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             bit_last,
    output logic             ready,
    output logic [WIDTH-1:0] crc,
    output logic             crc_valid,
    output logic             ser_out,
    output logic             ser_valid,
    output logic [CW-1:0]    bit_count,
    output logic             ovf
);

    localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] crc_q, crc_d;
    logic [CW-1:0]    bit_count_q, bit_count_d;
    logic             ovf_q, ovf_d;
    logic             crc_valid_q, crc_valid_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [SW-1:0]    shcnt_q, shcnt_d;

    logic             frame_open;
    logic             in_frame;
    logic [WIDTH-1:0] base_crc;
    logic [CW-1:0]    base_count;
    logic             base_ovf;
    logic             feedback;
    logic [WIDTH-1:0] stepped_crc;
    logic             frame_full;

    // A start outside SHIFT re-seeds the frame; a same-cycle bit is then processed against INIT.
    assign frame_open  = start && (state_q != ST_SHIFT);
    assign in_frame    = frame_open || (state_q == ST_ACCUM);
    assign base_crc    = frame_open ? INIT : crc_q;
    assign base_count  = frame_open ? '0 : bit_count_q;
    assign base_ovf    = frame_open ? 1'b0 : ovf_q;
    assign feedback    = base_crc[WIDTH-1] ^ bit_in;
    assign stepped_crc = {base_crc[WIDTH-2:0], 1'b0} ^ (feedback ? POLY : '0);
    assign frame_full  = (base_count == CW'(MAX_BITS));

    always_comb begin
        state_d     = state_q;
        crc_d       = crc_q;
        bit_count_d = bit_count_q;
        ovf_d       = ovf_q;
        crc_valid_d = 1'b0;
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        shreg_d     = shreg_q;
        shcnt_d     = shcnt_q;

        if (state_q == ST_SHIFT) begin
            if (shcnt_q == SW'(WIDTH - 1)) begin
                state_d = ST_IDLE;
            end else begin
                ser_valid_d = 1'b1;
                ser_out_d   = shreg_q[WIDTH-1];
                shreg_d     = {shreg_q[WIDTH-2:0], 1'b0};
                shcnt_d     = shcnt_q + SW'(1);
            end
        end else if (in_frame) begin
            state_d     = ST_ACCUM;
            crc_d       = base_crc;
            bit_count_d = base_count;
            ovf_d       = base_ovf;
            if (bit_valid) begin
                if (frame_full) begin
                    ovf_d = 1'b1;
                end else begin
                    crc_d       = stepped_crc;
                    bit_count_d = base_count + CW'(1);
                end
                // The serializer gets its own copy so crc stays frozen while shifting.
                if (bit_last) begin
                    state_d     = ST_SHIFT;
                    crc_valid_d = 1'b1;
                    ser_valid_d = 1'b1;
                    ser_out_d   = crc_d[WIDTH-1];
                    shreg_d     = {crc_d[WIDTH-2:0], 1'b0};
                    shcnt_d     = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            crc_q       <= INIT;
            bit_count_q <= '0;
            ovf_q       <= 1'b0;
            crc_valid_q <= 1'b0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            shreg_q     <= '0;
            shcnt_q     <= '0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            bit_count_q <= bit_count_d;
            ovf_q       <= ovf_d;
            crc_valid_q <= crc_valid_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            shreg_q     <= shreg_d;
            shcnt_q     <= shcnt_d;
        end
    end

    assign ready     = (state_q != ST_SHIFT);
    assign crc       = crc_q;
    assign crc_valid = crc_valid_q;
    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign bit_count = bit_count_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_crc_serial_engine.sv
// tb/tb_crc_serial_engine.sv - randomized self-checking bench for crc_serial_engine against a long-division CRC model
module tb_crc_serial_engine;

    logic clk = 1'b0;
    logic rst_n;
    logic start, bit_valid, bit_in, bit_last;

    logic       ready_a, crc_valid_a, ser_out_a, ser_valid_a, ovf_a;
    logic [7:0] crc_a;
    logic [8:0] bit_count_a;
    logic       ready_b, crc_valid_b, ser_out_b, ser_valid_b, ovf_b;
    logic [7:0] crc_b;
    logic [3:0] bit_count_b;

    int checks = 0;
    int errors = 0;
    logic cv_seen;

    always #5 clk = ~clk;

    crc_serial_engine dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid), .bit_in(bit_in),
        .bit_last(bit_last), .ready(ready_a), .crc(crc_a), .crc_valid(crc_valid_a),
        .ser_out(ser_out_a), .ser_valid(ser_valid_a), .bit_count(bit_count_a), .ovf(ovf_a)
    );

    crc_serial_engine #(.MAX_BITS(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid), .bit_in(bit_in),
        .bit_last(bit_last), .ready(ready_b), .crc(crc_b), .crc_valid(crc_valid_b),
        .ser_out(ser_out_b), .ser_valid(ser_valid_b), .bit_count(bit_count_b), .ovf(ovf_b)
    );

    // Remainder of M(x)*x^8 divided by x^8+x^2+x+1, taken on the first maxb message bits.
    function automatic logic [7:0] model_crc(input logic bits[$], input int maxb);
        logic [8:0] r = 9'h000;
        int n = (bits.size() < maxb) ? bits.size() : maxb;
        for (int i = 0; i < n + 8; i++) begin
            r = {r[7:0], (i < n) ? bits[i] : 1'b0};
            if (r[8]) r = r ^ 9'h107;
        end
        return r[7:0];
    endfunction

    task automatic drive(input logic st, input logic v, input logic b, input logic l);
        start = st; bit_valid = v; bit_in = b; bit_last = l;
        @(posedge clk); #1;
        start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; bit_last = 1'b0;
        if (crc_valid_a) cv_seen = 1'b1;
    endtask

    task automatic send_bits(input logic bits[$], input int gap_max, input logic with_start, input logic with_last);
        if (with_start) drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < bits.size(); i++) begin
            repeat ($urandom_range(0, gap_max)) drive(1'b0, 1'b0, 1'($urandom), 1'($urandom));
            drive(1'b0, 1'b1, bits[i], with_last && (i == bits.size() - 1));
        end
    endtask

    task automatic collect_ser(input logic inject, output logic [7:0] sa, output logic [7:0] sb,
                               output int nva, output int low_a, output logic extra_cv);
        sa = 8'h00; sb = 8'h00; nva = 0; low_a = 0; extra_cv = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (ser_valid_a) begin sa = {sa[6:0], ser_out_a}; nva++; end
            if (ser_valid_b) sb = {sb[6:0], ser_out_b};
            if (!ready_a) low_a++;
            if (k > 0 && (crc_valid_a || crc_valid_b)) extra_cv = 1'b1;
            if (inject) begin
                start = 1'b1; bit_valid = 1'b1; bit_in = 1'($urandom); bit_last = 1'($urandom);
            end
            @(posedge clk); #1;
            start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; bit_last = 1'b0;
        end
    endtask

    function automatic void push_byte(inout logic q[$], input logic [7:0] v);
        for (int i = 7; i >= 0; i--) q.push_back(v[i]);
    endfunction

    task automatic test_reset();
        logic q[$];
        int seen;
        checks++; if (ready_a !== 1'b1 || crc_a !== 8'h00 || bit_count_a !== 9'd0 || ovf_a !== 1'b0 || ser_valid_a !== 1'b0 || crc_valid_a !== 1'b0)
            begin errors++; $display("FAIL reset_initial: ready=%b crc=%h cnt=%0d ovf=%b sv=%b cv=%b exp 1/00/0/0/0/0", ready_a, crc_a, bit_count_a, ovf_a, ser_valid_a, crc_valid_a); end
        for (int i = 0; i < 10; i++) q.push_back(1'($urandom));
        send_bits(q, 1, 1'b1, 1'b0);
        checks++; if (ovf_b !== 1'b1) begin errors++; $display("FAIL reset_pre_ovf: got %b exp 1", ovf_b); end
        rst_n = 1'b0; #2;
        checks++; if (ready_a !== 1'b1 || crc_a !== 8'h00 || bit_count_a !== 9'd0 || ovf_a !== 1'b0 || ser_valid_a !== 1'b0)
            begin errors++; $display("FAIL reset_async: ready=%b crc=%h cnt=%0d ovf=%b sv=%b exp 1/00/0/0/0", ready_a, crc_a, bit_count_a, ovf_a, ser_valid_a); end
        checks++; if (ovf_b !== 1'b0 || bit_count_b !== 4'd0) begin errors++; $display("FAIL reset_async_b: ovf=%b cnt=%0d exp 0/0", ovf_b, bit_count_b); end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (ready_a !== 1'b1 || crc_a !== 8'h00) begin errors++; $display("FAIL reset_release: ready=%b crc=%h exp 1/00", ready_a, crc_a); end
        q.delete(); push_byte(q, 8'hA5);
        send_bits(q, 0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0); drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0; #2;
        checks++; if (ser_valid_a !== 1'b0 || ready_a !== 1'b1 || crc_a !== 8'h00) begin errors++; $display("FAIL reset_shift: sv=%b ready=%b crc=%h exp 0/1/00", ser_valid_a, ready_a, crc_a); end
        #1 rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin drive(1'b0, 1'b0, 1'b0, 1'b0); if (ser_valid_a) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL reset_shift_abandon: ser_valid cycles=%0d exp 0", seen); end
    endtask

    task automatic test_check_string();
        logic q[$];
        string s = "123456789";
        logic [7:0] sa, sb; int nva, low; logic xcv;
        for (int i = 0; i < s.len(); i++) push_byte(q, s[i]);
        send_bits(q, 0, 1'b1, 1'b1);
        checks++; if (crc_valid_a !== 1'b1 || crc_a !== 8'hF4) begin errors++; $display("FAIL string_crc: cv=%b crc=%h exp 1/f4", crc_valid_a, crc_a); end
        checks++; if (crc_a !== model_crc(q, 256)) begin errors++; $display("FAIL string_model: got %h exp %h", crc_a, model_crc(q, 256)); end
        checks++; if (bit_count_a !== 9'd72) begin errors++; $display("FAIL string_count: got %0d exp 72", bit_count_a); end
        collect_ser(1'b0, sa, sb, nva, low, xcv);
        checks++; if (sa !== 8'hF4 || nva !== 8) begin errors++; $display("FAIL string_serial: got %h (%0d bits) exp f4 (8 bits)", sa, nva); end
        checks++; if (low !== 8 || ready_a !== 1'b1 || ser_valid_a !== 1'b0 || xcv !== 1'b0)
            begin errors++; $display("FAIL string_ready: low=%0d ready=%b sv=%b extra_cv=%b exp 8/1/0/0", low, ready_a, ser_valid_a, xcv); end
        checks++; if (crc_a !== 8'hF4) begin errors++; $display("FAIL string_hold: got %h exp f4", crc_a); end
    endtask

    task automatic test_gaps();
        logic q[$];
        logic [7:0] sa, sb; int nva, low; logic xcv;
        push_byte(q, 8'h80);
        send_bits(q, 3, 1'b1, 1'b1);
        checks++; if (crc_a !== 8'h89 || bit_count_a !== 9'd8) begin errors++; $display("FAIL gaps_80: crc=%h cnt=%0d exp 89/8", crc_a, bit_count_a); end
        collect_ser(1'b0, sa, sb, nva, low, xcv);
        checks++; if (sa !== 8'h89) begin errors++; $display("FAIL gaps_80_serial: got %h exp 89", sa); end
        q.delete(); push_byte(q, 8'h01);
        send_bits(q, 2, 1'b1, 1'b1);
        checks++; if (crc_a !== 8'h07 || crc_valid_a !== 1'b1) begin errors++; $display("FAIL gaps_01: crc=%h cv=%b exp 07/1", crc_a, crc_valid_a); end
        collect_ser(1'b0, sa, sb, nva, low, xcv);
    endtask

    task automatic test_simultaneous();
        logic q[$];
        logic [7:0] sa, sb; int nva, low; logic xcv;
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        checks++; if (crc_valid_a !== 1'b1 || crc_a !== 8'h07 || bit_count_a !== 9'd1)
            begin errors++; $display("FAIL one_bit_frame: cv=%b crc=%h cnt=%0d exp 1/07/1", crc_valid_a, crc_a, bit_count_a); end
        collect_ser(1'b0, sa, sb, nva, low, xcv);
        checks++; if (sa !== 8'h07) begin errors++; $display("FAIL one_bit_serial: got %h exp 07", sa); end
        for (int i = 0; i < 5; i++) q.push_back(1'($urandom));
        send_bits(q, 1, 1'b1, 1'b0);
        cv_seen = 1'b0;
        q.delete(); for (int i = 0; i < 7; i++) q.push_back(1'b0);
        send_bits(q, 1, 1'b1, 1'b0);
        checks++; if (cv_seen !== 1'b0 || ready_a !== 1'b1) begin errors++; $display("FAIL abort_no_cv: cv_seen=%b ready=%b exp 0/1", cv_seen, ready_a); end
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        checks++; if (crc_a !== 8'h07 || bit_count_a !== 9'd8 || crc_valid_a !== 1'b1)
            begin errors++; $display("FAIL abort_crc: crc=%h cnt=%0d cv=%b exp 07/8/1", crc_a, bit_count_a, crc_valid_a); end
        collect_ser(1'b0, sa, sb, nva, low, xcv);
        q.delete(); for (int i = 0; i < 3; i++) q.push_back(1'($urandom));
        send_bits(q, 0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        q.delete(); for (int i = 0; i < 7; i++) q.push_back(1'b0);
        send_bits(q, 1, 1'b0, 1'b1);
        checks++; if (crc_a !== 8'h89 || bit_count_a !== 9'd8) begin errors++; $display("FAIL restart_with_bit: crc=%h cnt=%0d exp 89/8", crc_a, bit_count_a); end
        collect_ser(1'b0, sa, sb, nva, low, xcv);
    endtask

    task automatic test_shift_blocking();
        logic q[$];
        logic [7:0] exp_crc, sa, sb; int nva, low; logic xcv;
        push_byte(q, 8'($urandom));
        exp_crc = model_crc(q, 256);
        send_bits(q, 1, 1'b1, 1'b1);
        collect_ser(1'b1, sa, sb, nva, low, xcv);
        checks++; if (sa !== exp_crc || nva !== 8) begin errors++; $display("FAIL block_serial: got %h (%0d bits) exp %h (8)", sa, nva, exp_crc); end
        checks++; if (crc_a !== exp_crc || bit_count_a !== 9'd8 || xcv !== 1'b0)
            begin errors++; $display("FAIL block_state: crc=%h cnt=%0d extra_cv=%b exp %h/8/0", crc_a, bit_count_a, xcv, exp_crc); end
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (crc_a !== exp_crc || bit_count_a !== 9'd8 || crc_valid_a !== 1'b0 || ready_a !== 1'b1)
            begin errors++; $display("FAIL idle_ignore: crc=%h cnt=%0d cv=%b ready=%b exp %h/8/0/1", crc_a, bit_count_a, crc_valid_a, ready_a, exp_crc); end
    endtask

    task automatic test_overflow();
        logic q[$];
        logic [7:0] sa, sb; int nva, low; logic xcv;
        push_byte(q, 8'h01); q.push_back(1'b1); q.push_back(1'b1);
        send_bits(q, 1, 1'b1, 1'b1);
        checks++; if (ovf_b !== 1'b1 || bit_count_b !== 4'd8 || crc_b !== 8'h07 || crc_valid_b !== 1'b1)
            begin errors++; $display("FAIL ovf_frame: ovf=%b cnt=%0d crc=%h cv=%b exp 1/8/07/1", ovf_b, bit_count_b, crc_b, crc_valid_b); end
        checks++; if (ovf_a !== 1'b0 || crc_a !== model_crc(q, 256) || bit_count_a !== 9'd10)
            begin errors++; $display("FAIL ovf_wide: ovf=%b crc=%h cnt=%0d exp 0/%h/10", ovf_a, crc_a, bit_count_a, model_crc(q, 256)); end
        collect_ser(1'b0, sa, sb, nva, low, xcv);
        checks++; if (sb !== 8'h07 || ovf_b !== 1'b1) begin errors++; $display("FAIL ovf_serial: ser=%h ovf=%b exp 07/1", sb, ovf_b); end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (ovf_b !== 1'b0 || bit_count_b !== 4'd0 || crc_b !== 8'h00)
            begin errors++; $display("FAIL ovf_clear: ovf=%b cnt=%0d crc=%h exp 0/0/00", ovf_b, bit_count_b, crc_b); end
    endtask

    task automatic test_random();
        logic q[$];
        logic [7:0] ea, eb, sa, sb; int nva, low, len; logic xcv;
        for (int f = 0; f < 8; f++) begin
            q.delete();
            len = $urandom_range(1, 14);
            for (int i = 0; i < len; i++) q.push_back(1'($urandom));
            ea = model_crc(q, 256);
            eb = model_crc(q, 8);
            send_bits(q, 2, 1'b1, 1'b1);
            checks++; if (crc_valid_a !== 1'b1 || crc_a !== ea || bit_count_a !== 9'(len))
                begin errors++; $display("FAIL rand_a[%0d]: cv=%b crc=%h cnt=%0d exp 1/%h/%0d", f, crc_valid_a, crc_a, bit_count_a, ea, len); end
            checks++; if (crc_b !== eb || bit_count_b !== 4'((len > 8) ? 8 : len) || ovf_b !== (len > 8))
                begin errors++; $display("FAIL rand_b[%0d]: crc=%h cnt=%0d ovf=%b exp %h/%0d/%b", f, crc_b, bit_count_b, ovf_b, eb, (len > 8) ? 8 : len, len > 8); end
            collect_ser(1'($urandom), sa, sb, nva, low, xcv);
            checks++; if (sa !== ea || sb !== eb || ready_a !== 1'b1)
                begin errors++; $display("FAIL rand_ser[%0d]: a=%h b=%h ready=%b exp %h/%h/1", f, sa, sb, ready_a, ea, eb); end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; bit_last = 1'b0; cv_seen = 1'b0;
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_check_string();
        test_gaps();
        test_simultaneous();
        test_shift_blocking();
        test_overflow();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
